// File: rtl/fir_tdm_scheduler_if.sv
// Sample-in / filtered-out bus plus the shared MAC, sample RAM and coefficient ROM strobes.
// master = scheduler side, slave = datapath/environment side.
interface fir_tdm_scheduler_if #(
  parameter int M    = 14,
  parameter int AW   = 5,
  parameter int ACCW = 34
);
  logic                   sample_valid;
  logic signed [M-1:0]    va;
  logic signed [M-1:0]    vb;
  logic signed [M-1:0]    vc;
  logic                   busy;
  logic                   overrun;
  logic                   ram_we;
  logic [AW+1:0]          ram_addr;
  logic signed [M-1:0]    ram_wdata;
  logic [AW-1:0]          coef_addr;
  logic                   mac_clr;
  logic                   mac_en;
  logic signed [ACCW-1:0] acc_in;
  logic signed [M-1:0]    ya;
  logic signed [M-1:0]    yb;
  logic signed [M-1:0]    yc;
  logic                   out_valid;

  modport master (
    input  sample_valid, va, vb, vc, acc_in,
    output busy, overrun, ram_we, ram_addr, ram_wdata, coef_addr,
           mac_clr, mac_en, ya, yb, yc, out_valid
  );

  modport slave (
    output sample_valid, va, vb, vc, acc_in,
    input  busy, overrun, ram_we, ram_addr, ram_wdata, coef_addr,
           mac_clr, mac_en, ya, yb, yc, out_valid
  );
endinterface

// File: rtl/fir_tdm_scheduler.sv
// Time-shares one external MAC, sample RAM and coefficient ROM across three FIR phases (a/b/c).
// Latency 113 clk per sample set; no backpressure: sets arriving while busy are dropped and flag overrun.
module fir_tdm_scheduler #(
  parameter int M       = 14,
  parameter int TAPS    = 32,
  parameter int AW      = 5,
  parameter int ACCW    = 34,
  parameter int FRAC    = 13,
  parameter int MAC_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  fir_tdm_scheduler_if.master bus
);
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_STORE, S_DONE
  } state_t;

  localparam int CW = AW + 2;
  localparam logic [CW-1:0] INIT_END  = CW'(3 * TAPS);
  localparam logic [CW-1:0] LAST_TAP  = CW'(TAPS - 1);
  localparam logic [CW-1:0] DRAIN_END = CW'(MAC_LAT);
  localparam logic signed [ACCW-1:0] SMAX = (ACCW'(1) <<< (M - 1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] SMIN = ~SMAX;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [1:0]          ph;
  logic [AW-1:0]       wp;
  logic signed [M-1:0] lb;
  logic signed [M-1:0] lc;
  logic signed [ACCW-1:0] r;
  logic signed [M-1:0] sat;

  always_comb begin
    r = bus.acc_in >>> FRAC;
    if (r > SMAX)      sat = SMAX[M-1:0];
    else if (r < SMIN) sat = SMIN[M-1:0];
    else               sat = r[M-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_INIT;
      cnt           <= '0;
      ph            <= '0;
      wp            <= '0;
      lb            <= '0;
      lc            <= '0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.coef_addr <= '0;
      bus.mac_clr   <= 1'b0;
      bus.mac_en    <= 1'b0;
      bus.ya        <= '0;
      bus.yb        <= '0;
      bus.yc        <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.ram_we    <= 1'b0;
      bus.out_valid <= 1'b0;
      // Address registers are the issue stage; one more flop lines the strobes up with read data.
      bus.mac_en    <= (state == S_MAC);
      bus.mac_clr   <= (state == S_MAC) && (cnt == '0);
      if (bus.sample_valid && state != S_IDLE) bus.overrun <= 1'b1;

      case (state)
        S_INIT: begin
          if (cnt == INIT_END) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
            cnt      <= '0;
          end else begin
            bus.busy      <= 1'b1;
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= cnt;
            bus.ram_wdata <= '0;
            cnt           <= cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (bus.sample_valid) begin
            wp            <= wp + AW'(1);
            lb            <= bus.vb;
            lc            <= bus.vc;
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= {2'd0, AW'(wp + AW'(1))};
            bus.ram_wdata <= bus.va;
            bus.busy      <= 1'b1;
            cnt           <= '0;
            state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt == CW'(2)) begin
            state         <= S_MAC;
            ph            <= 2'd0;
            cnt           <= '0;
            bus.ram_addr  <= {2'd0, wp};
            bus.coef_addr <= '0;
          end else begin
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= {cnt[1:0] + 2'd1, wp};
            bus.ram_wdata <= (cnt == '0) ? lb : lc;
            cnt           <= cnt + CW'(1);
          end
        end
        S_MAC: begin
          if (cnt == LAST_TAP) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            // Newest sample pairs with coef 0; the index wraps modulo TAPS by width.
            cnt           <= cnt + CW'(1);
            bus.ram_addr  <= {ph, AW'(wp - cnt[AW-1:0] - AW'(1))};
            bus.coef_addr <= cnt[AW-1:0] + AW'(1);
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_END) begin
            state <= S_STORE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STORE: begin
          case (ph)
            2'd0:    bus.ya <= sat;
            2'd1:    bus.yb <= sat;
            default: bus.yc <= sat;
          endcase
          if (ph == 2'd2) begin
            state         <= S_DONE;
            bus.out_valid <= 1'b1;
          end else begin
            ph            <= ph + 2'd1;
            state         <= S_MAC;
            cnt           <= '0;
            bus.ram_addr  <= {ph + 2'd1, wp};
            bus.coef_addr <= '0;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Directed bench for fir_tdm_scheduler with behavioural sample RAM, coefficient ROM and 2-stage MAC.
module tb_fir_tdm_scheduler;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  fir_tdm_scheduler_if #(.M(14), .AW(5), .ACCW(34)) bus ();

  fir_tdm_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM/ROM (1-cycle read) and MAC (product stage + accumulate stage).
  logic signed [13:0] mem [128];
  logic signed [13:0] rdat;
  int                 coef [32];
  int                 cdat;
  longint             p1;
  longint             acc;
  logic               e1;
  logic               c1;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    rdat <= mem[bus.ram_addr];
    cdat <= coef[bus.coef_addr];
    if (bus.mac_en) p1 <= longint'(rdat) * longint'(cdat);
    e1 <= bus.mac_en;
    c1 <= bus.mac_clr;
    if (e1) acc <= c1 ? p1 : acc + p1;
  end
  assign bus.acc_in = acc[33:0];

  int mac_tot = 0;
  int clr_tot = 0;
  int we_tot  = 0;
  int ov_tot  = 0;
  always @(negedge clk) begin
    if (bus.mac_en)    mac_tot <= mac_tot + 1;
    if (bus.mac_clr)   clr_tot <= clr_tot + 1;
    if (bus.ram_we)    we_tot  <= we_tot + 1;
    if (bus.out_valid) ov_tot  <= ov_tot + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_coef(input int v0, input int v1, input int rest);
    for (int i = 0; i < 32; i++) coef[i] = rest;
    coef[0] = v0;
    coef[1] = v1;
  endtask

  task automatic hold_reset();
    bus.sample_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Called in the cycle right after the last reset edge; that cycle is numbered 0.
  task automatic release_init();
    int we_n, bad, busy_fall, m0;
    we_n = 0; bad = 0; busy_fall = 0; m0 = mac_tot;
    rst = 1'b0;
    for (int n = 1; n <= 110; n++) begin
      @(negedge clk);
      if (bus.ram_we) begin
        if (int'(bus.ram_addr) != we_n || int'(bus.ram_wdata) != 0) bad++;
        we_n++;
      end
      if (!bus.busy && busy_fall == 0) busy_fall = n;
    end
    chk("init.we_count", we_n, 96);
    chk("init.addr_data", bad, 0);
    chk("init.busy_fall", busy_fall, 97);
    chk("init.mac_en", mac_tot - m0, 0);
  endtask

  task automatic set_chk(input string tag, input int a, input int b, input int c,
                         input int ea, input int eb, input int ec);
    int lat, m0, c0, w0;
    m0 = mac_tot; c0 = clr_tot; w0 = we_tot;
    bus.va = 14'(a);
    bus.vb = 14'(b);
    bus.vc = 14'(c);
    bus.sample_valid = 1'b1;
    lat = 1;
    do begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      lat++;
    end while (!bus.out_valid && lat < 400);
    chk({tag, ".latency"}, lat, 113);
    chk({tag, ".ya"}, int'(bus.ya), ea);
    chk({tag, ".yb"}, int'(bus.yb), eb);
    chk({tag, ".yc"}, int'(bus.yc), ec);
    chk({tag, ".mac_en"}, mac_tot - m0, 96);
    chk({tag, ".mac_clr"}, clr_tot - c0, 3);
    chk({tag, ".ram_we"}, we_tot - w0, 3);
    @(negedge clk);
    chk({tag, ".pulse_len"}, int'(bus.out_valid), 0);
    chk({tag, ".idle"}, int'(bus.busy), 0);
  endtask

  initial begin
    int n, o0, ma;
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.va = '0;
    bus.vb = '0;
    bus.vc = '0;
    set_coef(8192, 0, 0);

    // Reset state and RAM clear.
    hold_reset();
    chk("rst.busy", int'(bus.busy), 0);
    chk("rst.ram_we", int'(bus.ram_we), 0);
    chk("rst.ram_addr", int'(bus.ram_addr), 0);
    chk("rst.coef_addr", int'(bus.coef_addr), 0);
    chk("rst.mac_en", int'(bus.mac_en), 0);
    chk("rst.mac_clr", int'(bus.mac_clr), 0);
    chk("rst.out_valid", int'(bus.out_valid), 0);
    chk("rst.overrun", int'(bus.overrun), 0);
    chk("rst.ya", int'(bus.ya), 0);
    chk("rst.yb", int'(bus.yb), 0);
    chk("rst.yc", int'(bus.yc), 0);
    release_init();

    // Impulse, then a pure one-sample delay to pin the read direction.
    set_chk("impulse", 1000, -500, 8191, 1000, -500, 8191);
    set_coef(0, 8192, 0);
    set_chk("delay1", 2000, 7, -3, 1000, -500, 8191);
    set_chk("delay2", 0, 0, 0, 2000, 7, -3);

    // Moving average over 40 sets: ramps by 100 and holds once the line is full, across wp wrap.
    hold_reset();
    release_init();
    set_coef(256, 256, 256);
    for (int i = 1; i <= 40; i++) begin
      ma = (i < 32) ? i * 100 : 3200;
      set_chk("mavg", 3200, -3200, 0, ma, -ma, 0);
    end

    // Saturation in both directions; the first set stays just inside the range.
    hold_reset();
    release_init();
    set_coef(8191, 8191, 8191);
    set_chk("satp1", 8191, -8192, 100, 8190, -8191, 99);
    set_chk("satp2", 8191, -8192, 100, 8191, -8192, 199);
    hold_reset();
    release_init();
    set_chk("satn1", -8192, 8191, -100, -8191, 8190, -100);
    set_chk("satn2", -8192, 8191, -100, -8192, 8191, -200);

    // Overrun: second strobe 50 cycles into the first computation.
    hold_reset();
    release_init();
    set_coef(8192, 0, 0);
    o0 = ov_tot;
    bus.va = 14'(1000);
    bus.vb = 14'(-500);
    bus.vc = 14'(8191);
    bus.sample_valid = 1'b1;
    n = 1;
    while (n < 50) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      n++;
    end
    chk("ovr.before", int'(bus.overrun), 0);
    bus.va = 14'(5);
    bus.vb = 14'(6);
    bus.vc = 14'(7);
    bus.sample_valid = 1'b1;
    do begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      n++;
    end while (!bus.out_valid && n < 400);
    chk("ovr.latency", n, 113);
    chk("ovr.ya", int'(bus.ya), 1000);
    chk("ovr.yb", int'(bus.yb), -500);
    chk("ovr.yc", int'(bus.yc), 8191);
    chk("ovr.flag", int'(bus.overrun), 1);
    repeat (200) @(negedge clk);
    chk("ovr.one_valid", ov_tot - o0, 1);
    chk("ovr.sticky", int'(bus.overrun), 1);

    // Reset 60 cycles into a computation.
    hold_reset();
    chk("mid.ovr_cleared", int'(bus.overrun), 0);
    release_init();
    set_chk("mid.pre", 1000, -500, 8191, 1000, -500, 8191);
    o0 = ov_tot;
    bus.va = 14'(300);
    bus.vb = 14'(-40);
    bus.vc = 14'(2);
    bus.sample_valid = 1'b1;
    n = 1;
    while (n < 60) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      n++;
    end
    chk("mid.ya_new", int'(bus.ya), 300);
    chk("mid.yb_held", int'(bus.yb), -500);
    chk("mid.busy", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid.ya_zero", int'(bus.ya), 0);
    chk("mid.yb_zero", int'(bus.yb), 0);
    chk("mid.yc_zero", int'(bus.yc), 0);
    chk("mid.busy_zero", int'(bus.busy), 0);
    chk("mid.valid_zero", int'(bus.out_valid), 0);
    release_init();
    chk("mid.no_valid", ov_tot - o0, 0);
    set_chk("mid.post", -1234, 77, -8192, -1234, 77, -8192);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fir_tdm_scheduler.md
Name: fir_tdm_scheduler

Overview:
- Time-division controller that shares one external multiply-accumulate (MAC) unit, one sample RAM and one coefficient ROM across the three phase inputs (a, b, c) of the sequence decomposer.
- Replaces three parallel order-32 FIR instances ahead of DC-offset removal.
- Per input sample set it does the following:
  - writes the three new samples into per-phase circular delay lines;
  - sequences TAPS MAC operations per phase;
  - rescales and saturates each accumulator result;
  - presents three filtered outputs together.

Parameters:
- M, 14, signed sample width in and out
- TAPS, 32, filter length; power of two
- AW, 5, log2(TAPS)
- ACCW, 34, external accumulator width
- FRAC, 13, coefficient fractional bits; result = acc >>> FRAC
- MAC_LAT, 2, cycles from the last aligned mac_en until acc_in is final

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe: va/vb/vc hold a new sample set
- va, vb, vc  in  M each, signed  phase samples
- busy  out  1  high whenever the FSM is not in IDLE
- overrun  out  1  sticky; set when sample_valid is dropped; cleared only by rst
- ram_we  out  1  sample RAM write enable
- ram_addr  out  AW+2  {phase[1:0], idx[AW-1:0]}
- ram_wdata  out  M  sample RAM write data
- coef_addr  out  AW  coefficient ROM address (shared by all phases)
- mac_clr  out  1  MAC loads the product instead of accumulating
- mac_en  out  1  MAC accumulates this cycle
- acc_in  in  ACCW, signed  accumulator value from the MAC
- ya, yb, yc  out  M each, signed  filtered outputs
- out_valid  out  1  one-cycle pulse when ya/yb/yc are all updated

Behaviour:
- RAM and ROM both have a 1-cycle synchronous read.
  - mac_en and mac_clr are the address-issue strobes delayed one register stage, so they align with the read data at the MAC.
- Write pointer wp (AW bits) is the index of the newest sample.
- On rst:
  - all outputs are 0;
  - wp=0, overrun=0;
  - FSM enters INIT.
- INIT:
  - writes 0 to all 3*TAPS RAM addresses, one per cycle, in ascending order (96 cycles at defaults);
  - busy=1; then goes to IDLE.
- IDLE:
  - busy=0;
  - on sample_valid: latch va/vb/vc, set wp <= wp+1 (mod TAPS), go to LOAD.
- LOAD: 3 cycles, writing phase 0/1/2 at {ph, wp_new} with the latched sample.
- MAC: per phase ph=0..2, TAPS cycles, k=0..TAPS-1:
  - ram_addr={ph, (wp-k) mod TAPS};
  - coef_addr=k;
  - the issue strobe carries clr for k=0 only.
- DRAIN: MAC_LAT+1 cycles after the last aligned mac_en, then STORE.
- STORE: 1 cycle.
  - r = acc_in >>> FRAC (arithmetic shift);
  - saturate r to [-2^(M-1), 2^(M-1)-1];
  - write the result to ya/yb/yc according to ph;
  - if ph<2, go to MAC with ph+1; otherwise go to DONE.
- DONE: out_valid=1 for 1 cycle, then IDLE.
- Sample-set period at defaults: 1 + 3 + 3*(32+3+1) + 1 = 113 cycles. Upstream sample rate must leave at least 113 clocks between strobes.
- Outputs ya/yb/yc hold their values between updates. Outputs for earlier phases update before out_valid; consumers must use only out_valid.
- sample_valid while busy=1 (any state incl. INIT):
  - the set is dropped; overrun <= 1;
  - the in-progress computation is unaffected;
  - sample_valid in the same cycle that DONE returns to IDLE is also dropped.
- rst mid-operation:
  - immediate abort; outputs zeroed; no out_valid;
  - INIT re-clears the RAM.
- wp wraps from TAPS-1 to 0; the read index modulo wraps the same way.
- mac_en/mac_clr are never asserted outside MAC, nor outside the single delayed cycle after MAC.
- ram_we is asserted only in INIT and LOAD.

Test Plan:
1. Reset, then hold:
   - exactly 96 ram_we cycles, addresses 0..95, data 0;
   - busy falls on cycle 97;
   - no mac_en.
2. Impulse (bench ROM coef[0]=8192, others 0; behavioural MAC):
   - input va=1000, vb=-500, vc=8191;
   - out_valid 113 cycles after the strobe with ya=1000, yb=-500, yc=8191.
3. Moving average (all coef=256, i.e. 1/32 at FRAC=13):
   - 40 steps of va=3200;
   - ya ramps 100, 200, … and saturates nowhere, holding at 3200 after 32 sets;
   - verifies wp wrap past index 31.
4. Saturation (coef all 8191, inputs 8191):
   - ya=8191 clamped;
   - with inputs -8192, ya=-8192.
5. Overrun:
   - strobe again 50 cycles after the first;
   - overrun=1 stays set, the first result is correct, and no second out_valid occurs.
6. Reset asserted at cycle 60 of a computation:
   - outputs 0 the next cycle; INIT re-entered;
   - no out_valid;
   - a subsequent impulse test passes.
